// File: rtl/ysyx_23060136_ifu_bpu_if.sv
// Lookup/update bundle between the fetch/execute pipeline and the branch prediction unit.
// The pipeline side is the master and the BPU is the slave.
interface ysyx_23060136_ifu_bpu_if #(
  parameter int unsigned BITS_W = 32,
  parameter int unsigned GHR_W  = 6
);
  logic [BITS_W-1:0] IFU_pc;
  logic              BPU_pre_hit;
  logic              BPU_pre_take;
  logic [BITS_W-1:0] BPU_pre_target;
  logic [GHR_W-1:0]  BPU_pre_ghr;
  logic              UPD_valid;
  logic [BITS_W-1:0] UPD_pc;
  logic [GHR_W-1:0]  UPD_ghr;
  logic              UPD_taken;
  logic [BITS_W-1:0] UPD_target;
  logic              BPU_flush;

  modport master (
    output IFU_pc, UPD_valid, UPD_pc, UPD_ghr, UPD_taken, UPD_target, BPU_flush,
    input  BPU_pre_hit, BPU_pre_take, BPU_pre_target, BPU_pre_ghr
  );

  modport slave (
    input  IFU_pc, UPD_valid, UPD_pc, UPD_ghr, UPD_taken, UPD_target, BPU_flush,
    output BPU_pre_hit, BPU_pre_take, BPU_pre_target, BPU_pre_ghr
  );
endinterface

// File: rtl/ysyx_23060136_ifu_bpu.sv
// Branch prediction unit: saturating-counter BHT plus tagged BTB, bimodal or gshare indexed.
// Lookup is combinational from IFU_pc; resolved branches train it one per cycle.
module ysyx_23060136_ifu_bpu #(
  parameter int unsigned BITS_W = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned MODE   = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_23060136_ifu_bpu_if.slave   bus
);
  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned TagLo   = IDX_W + 2;
  localparam int unsigned TagHi   = IDX_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic              valid_q  [Entries];
  logic [TAG_W-1:0]  tag_q    [Entries];
  logic [BITS_W-1:0] target_q [Entries];
  logic [CNT_W-1:0]  cnt_q    [Entries];
  logic [GHR_W-1:0]  ghr_q;

  logic [IDX_W-1:0] lidx, uidx;
  logic [IDX_W-1:0] lghr_idx, ughr_idx;
  logic [TAG_W-1:0] ltag, utag;
  logic [CNT_W-1:0] cnt_cur, cnt_next;
  logic [GHR_W-1:0] ghr_next;

  // History is zero-extended into the index; bimodal mode ignores it entirely.
  assign lghr_idx = (MODE != 0) ? IDX_W'(ghr_q) : '0;
  assign ughr_idx = (MODE != 0) ? IDX_W'(bus.UPD_ghr) : '0;

  assign lidx = bus.IFU_pc[IDX_W+1:2] ^ lghr_idx;
  assign uidx = bus.UPD_pc[IDX_W+1:2] ^ ughr_idx;
  assign ltag = bus.IFU_pc[TagHi:TagLo];
  assign utag = bus.UPD_pc[TagHi:TagLo];

  assign bus.BPU_pre_hit    = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign bus.BPU_pre_take   = bus.BPU_pre_hit && cnt_q[lidx][CNT_W-1];
  assign bus.BPU_pre_target = bus.BPU_pre_take ? target_q[lidx] : bus.IFU_pc + BITS_W'(4);
  assign bus.BPU_pre_ghr    = (MODE != 0) ? ghr_q : '0;

  assign cnt_cur  = cnt_q[uidx];
  assign ghr_next = (ghr_q << 1) | GHR_W'(bus.UPD_taken);

  always_comb begin
    cnt_next = cnt_cur;
    if (bus.UPD_taken) begin
      if (cnt_cur != CntMax) cnt_next = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CntInit;
      end
    end else if (bus.BPU_flush) begin
      // Counters keep their training; only BTB validity and history are dropped.
      ghr_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.UPD_valid) begin
      cnt_q[uidx] <= cnt_next;
      if (bus.UPD_taken) begin
        valid_q[uidx]  <= 1'b1;
        tag_q[uidx]    <= utag;
        target_q[uidx] <= bus.UPD_target;
      end
      if (MODE != 0) ghr_q <= ghr_next;
    end
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^{bus.UPD_pc[1:0], bus.UPD_pc[BITS_W-1:TagHi+1]};

endmodule

// File: tb/tb_ysyx_23060136_ifu_bpu.sv
// Directed bench: one bimodal and one gshare BPU instance, hand-computed expectations.
module tb_ysyx_23060136_ifu_bpu;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_23060136_ifu_bpu_if #(.BITS_W(32), .GHR_W(6)) if0 ();
  ysyx_23060136_ifu_bpu_if #(.BITS_W(32), .GHR_W(6)) if1 ();

  ysyx_23060136_ifu_bpu #(
    .BITS_W(32), .IDX_W(6), .TAG_W(8), .CNT_W(2), .GHR_W(6), .MODE(0)
  ) u_bimodal (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  ysyx_23060136_ifu_bpu #(
    .BITS_W(32), .IDX_W(6), .TAG_W(8), .CNT_W(2), .GHR_W(6), .MODE(1)
  ) u_gshare (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  localparam logic [31:0] PcA = 32'h8000_0010;
  localparam logic [31:0] PcB = 32'h8000_0110;
  localparam logic [31:0] TgA = 32'h8000_0100;

  task automatic upd0(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    if0.UPD_pc = pc; if0.UPD_ghr = '0; if0.UPD_taken = taken; if0.UPD_target = tgt;
    if0.UPD_valid = 1'b1;
    @(posedge clk); #1;
    if0.UPD_valid = 1'b0;
  endtask

  task automatic upd1(input logic [31:0] pc, input logic [5:0] ghr, input logic taken,
                      input logic [31:0] tgt);
    if1.UPD_pc = pc; if1.UPD_ghr = ghr; if1.UPD_taken = taken; if1.UPD_target = tgt;
    if1.UPD_valid = 1'b1;
    @(posedge clk); #1;
    if1.UPD_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.IFU_pc = 32'h8000_0000; if1.IFU_pc = 32'h8000_0000;
    if0.UPD_valid = 0; if0.UPD_pc = 0; if0.UPD_ghr = 0; if0.UPD_taken = 0; if0.UPD_target = 0;
    if1.UPD_valid = 0; if1.UPD_pc = 0; if1.UPD_ghr = 0; if1.UPD_taken = 0; if1.UPD_target = 0;
    if0.BPU_flush = 0; if1.BPU_flush = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (if0.BPU_pre_hit !== 1'b0) begin errors++;
      $display("FAIL reset_hit got %0b want 0", if0.BPU_pre_hit); end
    checks++; if (if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL reset_take got %0b want 0", if0.BPU_pre_take); end
    checks++; if (if0.BPU_pre_target !== 32'h8000_0004) begin errors++;
      $display("FAIL reset_target got %h want 80000004", if0.BPU_pre_target); end
    checks++; if (if1.BPU_pre_ghr !== 6'd0) begin errors++;
      $display("FAIL reset_ghr got %b want 000000", if1.BPU_pre_ghr); end
  endtask

  task automatic test_train();
    upd0(PcA, 1'b1, TgA);
    upd0(PcA, 1'b1, TgA);
    if0.IFU_pc = PcA; #1;
    checks++; if (if0.BPU_pre_hit !== 1'b1) begin errors++;
      $display("FAIL train_hit got %0b want 1", if0.BPU_pre_hit); end
    checks++; if (if0.BPU_pre_take !== 1'b1) begin errors++;
      $display("FAIL train_take got %0b want 1", if0.BPU_pre_take); end
    checks++; if (if0.BPU_pre_target !== TgA) begin errors++;
      $display("FAIL train_target got %h want %h", if0.BPU_pre_target, TgA); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) upd0(PcA, 1'b1, TgA);
    upd0(PcA, 1'b0, 32'h0);
    checks++; if (if0.BPU_pre_take !== 1'b1) begin errors++;
      $display("FAIL sat_nt1_take got %0b want 1", if0.BPU_pre_take); end
    upd0(PcA, 1'b0, 32'h0);
    checks++; if (if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL sat_nt2_take got %0b want 0", if0.BPU_pre_take); end
    checks++; if (if0.BPU_pre_hit !== 1'b1) begin errors++;
      $display("FAIL sat_nt2_hit got %0b want 1", if0.BPU_pre_hit); end
    checks++; if (if0.BPU_pre_target !== PcA + 32'd4) begin errors++;
      $display("FAIL sat_nt2_target got %h want %h", if0.BPU_pre_target, PcA + 32'd4); end
  endtask

  // Counter at A's index is 1 here; also checks that a same-cycle update is not bypassed.
  task automatic test_alias();
    if0.IFU_pc = PcA;
    if0.UPD_pc = PcA; if0.UPD_taken = 1'b1; if0.UPD_target = TgA; if0.UPD_valid = 1'b1;
    #1;
    checks++; if (if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL nobypass_take got %0b want 0", if0.BPU_pre_take); end
    @(posedge clk); #1;
    if0.UPD_valid = 1'b0; #1;
    checks++; if (if0.BPU_pre_take !== 1'b1) begin errors++;
      $display("FAIL after_upd_take got %0b want 1", if0.BPU_pre_take); end
    if0.IFU_pc = PcB; #1;
    checks++; if (if0.BPU_pre_hit !== 1'b0) begin errors++;
      $display("FAIL alias_hit got %0b want 0", if0.BPU_pre_hit); end
    checks++; if (if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL alias_take got %0b want 0", if0.BPU_pre_take); end
    checks++; if (if0.BPU_pre_target !== 32'h8000_0114) begin errors++;
      $display("FAIL alias_target got %h want 80000114", if0.BPU_pre_target); end
    // Not-taken miss trains the shared counter (2->1) but allocates nothing.
    upd0(PcB, 1'b0, 32'h0);
    checks++; if (if0.BPU_pre_hit !== 1'b0) begin errors++;
      $display("FAIL nt_miss_alloc got %0b want 0", if0.BPU_pre_hit); end
    if0.IFU_pc = PcA; #1;
    checks++; if (if0.BPU_pre_hit !== 1'b1 || if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL nt_miss_train got hit=%0b take=%0b want hit=1 take=0",
               if0.BPU_pre_hit, if0.BPU_pre_take); end
  endtask

  // GHR 0 -> 1 -> 11 -> 110; pcs below are chosen so pc[7:2]^6 lands on trained entries.
  task automatic test_gshare();
    upd1(32'h8000_0040, 6'd0, 1'b1, 32'h8000_0200);
    upd1(32'h8000_0040, 6'd1, 1'b1, 32'h8000_0300);
    upd1(32'h8000_0040, 6'd3, 1'b0, 32'h0);
    checks++; if (if1.BPU_pre_ghr !== 6'b000110) begin errors++;
      $display("FAIL gshare_ghr got %b want 000110", if1.BPU_pre_ghr); end
    if1.IFU_pc = 32'h8000_0058; #1;
    checks++; if (if1.BPU_pre_hit !== 1'b1 || if1.BPU_pre_take !== 1'b1
                  || if1.BPU_pre_target !== 32'h8000_0200) begin errors++;
      $display("FAIL gshare_idx16 got hit=%0b take=%0b tgt=%h want 1 1 80000200",
               if1.BPU_pre_hit, if1.BPU_pre_take, if1.BPU_pre_target); end
    if1.IFU_pc = 32'h8000_005C; #1;
    checks++; if (if1.BPU_pre_target !== 32'h8000_0300) begin errors++;
      $display("FAIL gshare_idx17 got %h want 80000300", if1.BPU_pre_target); end
    if1.IFU_pc = 32'h8000_0040; #1;
    checks++; if (if1.BPU_pre_hit !== 1'b0 || if1.BPU_pre_target !== 32'h8000_0044) begin
      errors++;
      $display("FAIL gshare_idx22 got hit=%0b tgt=%h want 0 80000044",
               if1.BPU_pre_hit, if1.BPU_pre_target); end
  endtask

  task automatic test_flush();
    if0.BPU_flush = 1'b1; if1.BPU_flush = 1'b1;
    if0.UPD_pc = PcA; if0.UPD_taken = 1'b1; if0.UPD_target = 32'h8000_0400; if0.UPD_valid = 1;
    if1.UPD_pc = 32'h8000_0058; if1.UPD_ghr = 6'd6; if1.UPD_taken = 1'b1;
    if1.UPD_target = 32'h8000_0500; if1.UPD_valid = 1;
    @(posedge clk); #1;
    if0.BPU_flush = 0; if1.BPU_flush = 0; if0.UPD_valid = 0; if1.UPD_valid = 0;
    if0.IFU_pc = PcA; if1.IFU_pc = 32'h8000_0058; #1;
    checks++; if (if0.BPU_pre_hit !== 1'b0 || if0.BPU_pre_target !== 32'h8000_0014) begin
      errors++;
      $display("FAIL flush_hit0 got hit=%0b tgt=%h want 0 80000014",
               if0.BPU_pre_hit, if0.BPU_pre_target); end
    checks++; if (if1.BPU_pre_ghr !== 6'd0) begin errors++;
      $display("FAIL flush_ghr got %b want 000000", if1.BPU_pre_ghr); end
    checks++; if (if1.BPU_pre_hit !== 1'b0) begin errors++;
      $display("FAIL flush_hit1_pcq got %0b want 0", if1.BPU_pre_hit); end
    if1.IFU_pc = 32'h8000_0040; #1;
    checks++; if (if1.BPU_pre_hit !== 1'b0) begin errors++;
      $display("FAIL flush_hit1_pcp got %0b want 0", if1.BPU_pre_hit); end
    // Dropped update leaves counter at 1: taken -> 2, not-taken -> 1 means weakly not-taken.
    upd0(PcA, 1'b1, TgA);
    upd0(PcA, 1'b0, 32'h0);
    checks++; if (if0.BPU_pre_hit !== 1'b1 || if0.BPU_pre_take !== 1'b0) begin errors++;
      $display("FAIL flush_dropped_upd got hit=%0b take=%0b want hit=1 take=0",
               if0.BPU_pre_hit, if0.BPU_pre_take); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturate();
    test_alias();
    test_gshare();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
